// File: rtl/mmram_pkg.sv
// Shared widths, packet field offsets and error bit indices for the matching-memory pipeline.
package mmram_pkg;

  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned TAG_W  = 18;
  localparam int unsigned DATA_W = 16;

  // PACKET_IN = {MF, tag, LR, data}
  localparam int unsigned PIN_W        = 1 + TAG_W + 1 + DATA_W;
  localparam int unsigned PIN_DATA_LSB = 0;
  localparam int unsigned PIN_LR       = DATA_W;
  localparam int unsigned PIN_TAG_LSB  = DATA_W + 1;
  localparam int unsigned PIN_MF       = DATA_W + 1 + TAG_W;

  // PACKET_OUT = {SINGLE, tag, left, right}
  localparam int unsigned POUT_W         = 1 + TAG_W + 2 * DATA_W;
  localparam int unsigned POUT_RIGHT_LSB = 0;
  localparam int unsigned POUT_LEFT_LSB  = DATA_W;
  localparam int unsigned POUT_TAG_LSB   = 2 * DATA_W;
  localparam int unsigned POUT_SINGLE    = 2 * DATA_W + TAG_W;

  localparam int unsigned ERR_OVERWRITE   = 0;
  localparam int unsigned ERR_READ_MISS   = 1;
  localparam int unsigned ERR_ILLEGAL_CMD = 2;

endpackage

// File: rtl/mmram_array.sv
// Operand storage with per-entry valid bits: one write port, one async read port, one clear port.
module mmram_array
  import mmram_pkg::*;
#(
  parameter int unsigned Depth = DEPTH,
  parameter int unsigned AddrW = ADDR_W,
  parameter int unsigned DataW = DATA_W
) (
  input  logic             CP,
  input  logic             MR,
  input  logic             i_we,
  input  logic [AddrW-1:0] i_waddr,
  input  logic [DataW-1:0] i_wdata,
  input  logic             i_clr,
  input  logic [AddrW-1:0] i_caddr,
  input  logic [AddrW-1:0] i_raddr,
  output logic [DataW-1:0] o_rdata,
  output logic             o_rval
);

  logic [DataW-1:0] r_mem [Depth];
  logic [Depth-1:0] r_val;

  // Data is intentionally not reset; only the valid vector is.
  always_ff @(posedge CP) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge CP) begin
    if (MR) begin
      r_val <= '0;
    end else begin
      if (i_clr) r_val[i_caddr] <= 1'b0;
      if (i_we)  r_val[i_waddr] <= 1'b1;
    end
  end

  assign o_rdata = r_mem[i_raddr];
  assign o_rval  = r_val[i_raddr];

endmodule

// File: rtl/mmram_stage.sv
// Matching-memory RAM stage: parks first operands, pairs second operands, passes unmatched packets.
module mmram_stage
  import mmram_pkg::*;
#(
  parameter int unsigned DEPTH  = mmram_pkg::DEPTH,
  parameter int unsigned ADDR_W = mmram_pkg::ADDR_W,
  parameter int unsigned TAG_W  = mmram_pkg::TAG_W,
  parameter int unsigned DATA_W = mmram_pkg::DATA_W
) (
  input  logic                        CP,
  input  logic                        MR,
  input  logic                        Send_in,
  output logic                        Ack_out,
  input  logic [1+TAG_W+1+DATA_W-1:0] PACKET_IN,
  input  logic                        WR_E,
  input  logic                        DEL,
  input  logic [ADDR_W-1:0]           ADDR,
  output logic                        Send_out,
  input  logic                        Ack_in,
  output logic [1+TAG_W+2*DATA_W-1:0] PACKET_OUT,
  output logic [ADDR_W:0]             OCC,
  output logic [2:0]                  ERR
);

  localparam int unsigned OutW = 1 + TAG_W + 2 * DATA_W;
  localparam logic [ADDR_W:0] OccMax = DEPTH[ADDR_W:0];

  logic              r_out_v;
  logic [OutW-1:0]   r_pkt;
  logic [ADDR_W:0]   r_occ;
  logic [2:0]        r_err;

  logic              w_acc, w_mf, w_lr;
  logic [TAG_W-1:0]  w_tag;
  logic [DATA_W-1:0] w_data, w_partner;
  logic              w_pass, w_store, w_match, w_fire, w_val;
  logic              w_out_v_d;
  logic [OutW-1:0]   w_pkt_d;
  logic [ADDR_W:0]   w_occ_d;
  logic [2:0]        w_err_d;

  assign Ack_out = !r_out_v | Ack_in;
  assign w_acc   = Send_in & Ack_out;

  assign w_mf   = PACKET_IN[PIN_MF];
  assign w_lr   = PACKET_IN[PIN_LR];
  assign w_tag  = PACKET_IN[PIN_TAG_LSB +: TAG_W];
  assign w_data = PACKET_IN[PIN_DATA_LSB +: DATA_W];

  assign w_pass  = w_acc & !w_mf;
  assign w_store = w_acc & w_mf & WR_E;
  assign w_match = w_acc & w_mf & !WR_E;
  assign w_fire  = w_pass | w_match;

  mmram_array #(
    .Depth (DEPTH),
    .AddrW (ADDR_W),
    .DataW (DATA_W)
  ) u_array (
    .CP      (CP),
    .MR      (MR),
    .i_we    (w_store),
    .i_waddr (ADDR),
    .i_wdata (w_data),
    .i_clr   (w_match & DEL),
    .i_caddr (ADDR),
    .i_raddr (ADDR),
    .o_rdata (w_partner),
    .o_rval  (w_val)
  );

  always_comb begin
    w_out_v_d = r_out_v;
    w_pkt_d   = r_pkt;
    if (w_fire) begin
      w_out_v_d = 1'b1;
      if (w_pass)    w_pkt_d = {1'b1, w_tag, w_data, {DATA_W{1'b0}}};
      else if (w_lr) w_pkt_d = {1'b0, w_tag, w_partner, w_data};
      else           w_pkt_d = {1'b0, w_tag, w_data, w_partner};
    end else if (r_out_v & Ack_in) begin
      w_out_v_d = 1'b0;
    end
  end

  // A store to a free slot can't see OCC at max, so the guards only enforce saturation.
  always_comb begin
    w_occ_d = r_occ;
    w_err_d = r_err;
    if (w_store) begin
      if (w_val)                w_err_d[ERR_OVERWRITE]   = 1'b1;
      else if (r_occ != OccMax) w_occ_d = r_occ + 1'b1;
      if (DEL)                  w_err_d[ERR_ILLEGAL_CMD] = 1'b1;
    end else if (w_match) begin
      if (!w_val)                      w_err_d[ERR_READ_MISS] = 1'b1;
      else if (DEL && r_occ != '0)     w_occ_d = r_occ - 1'b1;
    end
  end

  always_ff @(posedge CP) begin
    if (MR) begin
      r_out_v <= 1'b0;
      r_pkt   <= '0;
      r_occ   <= '0;
      r_err   <= '0;
    end else begin
      r_out_v <= w_out_v_d;
      r_pkt   <= w_pkt_d;
      r_occ   <= w_occ_d;
      r_err   <= w_err_d;
    end
  end

  assign Send_out   = r_out_v;
  assign PACKET_OUT = r_pkt;
  assign OCC        = r_occ;
  assign ERR        = r_err;

endmodule

// File: tb/tb_mmram_stage.sv
// Directed bench for mmram_stage: pass, store/match, backpressure, fill, errors, mid-stream reset.
module tb_mmram_stage;

  logic        CP = 1'b0;
  logic        MR = 1'b1;
  logic        Send_in = 1'b0;
  logic        Ack_out;
  logic [35:0] PACKET_IN = '0;
  logic        WR_E = 1'b0;
  logic        DEL = 1'b0;
  logic [5:0]  ADDR = '0;
  logic        Send_out;
  logic        Ack_in = 1'b1;
  logic [50:0] PACKET_OUT;
  logic [6:0]  OCC;
  logic [2:0]  ERR;

  int checks = 0;
  int failures = 0;
  logic [50:0] exp_a;

  mmram_stage dut (
    .CP         (CP),
    .MR         (MR),
    .Send_in    (Send_in),
    .Ack_out    (Ack_out),
    .PACKET_IN  (PACKET_IN),
    .WR_E       (WR_E),
    .DEL        (DEL),
    .ADDR       (ADDR),
    .Send_out   (Send_out),
    .Ack_in     (Ack_in),
    .PACKET_OUT (PACKET_OUT),
    .OCC        (OCC),
    .ERR        (ERR)
  );

  always #5 CP = ~CP;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one packet for one edge, then idle the input; returns at edge+1.
  task automatic send(input logic mf, input logic [17:0] tag, input logic lr,
                      input logic [15:0] data, input logic we, input logic del,
                      input logic [5:0] addr);
    PACKET_IN = {mf, tag, lr, data};
    WR_E = we; DEL = del; ADDR = addr; Send_in = 1'b1;
    @(posedge CP); #1;
    Send_in = 1'b0; WR_E = 1'b0; DEL = 1'b0;
  endtask

  task automatic idle();
    @(posedge CP); #1;
  endtask

  task automatic do_reset();
    MR = 1'b1;
    @(posedge CP); #1;
    MR = 1'b0;
  endtask

  initial begin
    // Reset
    @(posedge CP); #1;
    do_reset();
    check("rst_send_out", 64'(Send_out), 64'd0);
    check("rst_occ", 64'(OCC), 64'd0);
    check("rst_err", 64'(ERR), 64'd0);
    check("rst_ack_out", 64'(Ack_out), 64'd1);
    check("rst_pkt", 64'(PACKET_OUT), 64'd0);

    // PASS
    send(1'b0, 18'h155, 1'b0, 16'h1234, 1'b0, 1'b0, 6'd0);
    check("pass_send_out", 64'(Send_out), 64'd1);
    check("pass_pkt", 64'(PACKET_OUT), 64'({1'b1, 18'h155, 16'h1234, 16'h0000}));
    check("pass_occ", 64'(OCC), 64'd0);
    idle();
    check("pass_drain", 64'(Send_out), 64'd0);

    // STORE then back-to-back MATCH
    send(1'b1, 18'h0AB, 1'b0, 16'hAAAA, 1'b1, 1'b0, 6'd5);
    check("store_no_out", 64'(Send_out), 64'd0);
    check("store_occ", 64'(OCC), 64'd1);
    send(1'b1, 18'h0AB, 1'b1, 16'hBBBB, 1'b0, 1'b1, 6'd5);
    check("match_send_out", 64'(Send_out), 64'd1);
    check("match_pkt", 64'(PACKET_OUT), 64'({1'b0, 18'h0AB, 16'hAAAA, 16'hBBBB}));
    check("match_occ", 64'(OCC), 64'd0);
    check("match_err", 64'(ERR), 64'd0);
    idle();

    // Backpressure
    Ack_in = 1'b0;
    send(1'b0, 18'h001, 1'b0, 16'h1111, 1'b0, 1'b0, 6'd0);
    exp_a = {1'b1, 18'h001, 16'h1111, 16'h0000};
    check("bp_first", 64'(PACKET_OUT), 64'(exp_a));
    PACKET_IN = {1'b0, 18'h002, 1'b0, 16'h2222};
    Send_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_ack_out", 64'(Ack_out), 64'd0);
      check("bp_hold", 64'(PACKET_OUT), 64'(exp_a));
      check("bp_valid", 64'(Send_out), 64'd1);
      @(posedge CP); #1;
    end
    Ack_in = 1'b1;
    #1;
    check("bp_release_ack", 64'(Ack_out), 64'd1);
    @(posedge CP); #1;
    Send_in = 1'b0;
    check("bp_second", 64'(PACKET_OUT), 64'({1'b1, 18'h002, 16'h2222, 16'h0000}));
    check("bp_second_valid", 64'(Send_out), 64'd1);
    idle();
    check("bp_no_dup", 64'(Send_out), 64'd0);

    // Fill all entries
    for (int i = 0; i < 64; i++) send(1'b1, 18'h010, 1'b0, 16'(i), 1'b1, 1'b0, 6'(i));
    check("fill_occ", 64'(OCC), 64'd64);
    check("fill_err", 64'(ERR), 64'd0);
    send(1'b1, 18'h010, 1'b0, 16'hE007, 1'b1, 1'b0, 6'd7);
    check("ovw_occ", 64'(OCC), 64'd64);
    check("ovw_err", 64'(ERR), 64'b001);
    send(1'b1, 18'h011, 1'b0, 16'h7777, 1'b0, 1'b1, 6'd7);
    check("fill_match_occ", 64'(OCC), 64'd63);
    check("fill_match_pkt", 64'(PACKET_OUT), 64'({1'b0, 18'h011, 16'h7777, 16'hE007}));
    idle();

    // Errors: read miss, illegal command, stickiness
    do_reset();
    send(1'b1, 18'h020, 1'b1, 16'h9999, 1'b0, 1'b0, 6'd9);
    check("miss_send_out", 64'(Send_out), 64'd1);
    check("miss_stale_pkt", 64'(PACKET_OUT), 64'({1'b0, 18'h020, 16'h0009, 16'h9999}));
    check("miss_err", 64'(ERR), 64'b010);
    send(1'b1, 18'h021, 1'b0, 16'h4444, 1'b1, 1'b1, 6'd20);
    check("illegal_err", 64'(ERR), 64'b110);
    check("illegal_occ", 64'(OCC), 64'd1);
    check("store_drains", 64'(Send_out), 64'd0);
    repeat (3) idle();
    check("err_sticky", 64'(ERR), 64'b110);

    // Mid-stream reset
    do_reset();
    for (int i = 1; i <= 3; i++) send(1'b1, 18'h030, 1'b0, 16'h5000 + 16'(i), 1'b1, 1'b0, 6'(i));
    check("mid_occ3", 64'(OCC), 64'd3);
    Ack_in = 1'b0;
    send(1'b0, 18'h031, 1'b0, 16'h6666, 1'b0, 1'b0, 6'd0);
    check("mid_pending", 64'(Send_out), 64'd1);
    do_reset();
    Ack_in = 1'b1;
    check("mid_send_out", 64'(Send_out), 64'd0);
    check("mid_occ", 64'(OCC), 64'd0);
    check("mid_err", 64'(ERR), 64'd0);
    check("mid_pkt", 64'(PACKET_OUT), 64'd0);
    send(1'b1, 18'h032, 1'b0, 16'h0C0C, 1'b0, 1'b1, 6'd2);
    check("post_rst_miss_err", 64'(ERR), 64'b010);
    check("post_rst_pkt", 64'(PACKET_OUT), 64'({1'b0, 18'h032, 16'h0C0C, 16'h5002}));
    check("post_rst_occ", 64'(OCC), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
